// File: rtl/aq_djpeg_pkg.sv
// Shared definitions for the JPEG decoder control blocks: scheduler state
// encoding, component color codes and the MCU-geometry helper.
package aq_djpeg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_RESTART = 2'd2,
      ST_DONE    = 2'd3
   } sched_state_e;

   localparam logic [2:0] COLOR_Y  = 3'd0;
   localparam logic [2:0] COLOR_CB = 3'd1;
   localparam logic [2:0] COLOR_CR = 3'd2;

   // Component count that selects the Cb/Cr blocks after the luma blocks.
   localparam logic [2:0] COMP_COLOR = 3'd3;

   // Index of the last luma block in an MCU. A sampling factor of 0 is
   // treated as 1; anything 2 or above is treated as 2.
   function automatic logic [1:0] last_luma_index(input logic [1:0] sub_w,
                                                  input logic [1:0] sub_h);
      logic two_w;
      logic two_h;
      logic [1:0] idx;
      two_w = (sub_w >= 2'd2);
      two_h = (sub_h >= 2'd2);
      if (two_w && two_h) begin
         idx = 2'd3;
      end else if (two_w || two_h) begin
         idx = 2'd1;
      end else begin
         idx = 2'd0;
      end
      return idx;
   endfunction

endpackage

// File: rtl/aq_djpeg_mcu_pos.sv
// MCU raster position counter: walks McuX across a row, wraps to the next
// row, and flags the final MCU of the scan.
module aq_djpeg_mcu_pos #(
   parameter int POS_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             adv,
   input  logic [POS_W-1:0] width,
   input  logic [POS_W-1:0] height,
   output logic [POS_W-1:0] mcu_x,
   output logic [POS_W-1:0] mcu_y,
   output logic             last_mcu
);

   localparam logic [POS_W-1:0] ONE  = {{(POS_W-1){1'b0}}, 1'b1};
   localparam logic [POS_W-1:0] ZERO = {POS_W{1'b0}};

   logic [POS_W-1:0] x_d, x_q;
   logic [POS_W-1:0] y_d, y_q;
   logic             row_end_s;

   assign row_end_s = (x_q == (width - ONE));
   assign last_mcu  = row_end_s && (y_q == (height - ONE));
   assign mcu_x     = x_q;
   assign mcu_y     = y_q;

   // Next position: clear wins, otherwise step along the row and wrap.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (clr) begin
         x_d = ZERO;
         y_d = ZERO;
      end else if (adv) begin
         if (row_end_s) begin
            x_d = ZERO;
            y_d = y_q + ONE;
         end else begin
            x_d = x_q + ONE;
            y_d = y_q;
         end
      end else begin
         x_d = x_q;
         y_d = y_q;
      end
   end

   // Position registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q <= ZERO;
         y_q <= ZERO;
      end else begin
         x_q <= x_d;
         y_q <= y_d;
      end
   end

endmodule

// File: rtl/aq_djpeg_mcu_sched.sv
// MCU scheduler for the baseline JPEG decoder: tells the entropy decoder
// which component/block comes next, tracks MCU position, and stalls the
// decoder at restart markers and at end of scan.
module aq_djpeg_mcu_sched
   import aq_djpeg_pkg::*;
#(
   parameter int POS_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ProcessInit,
   input  logic             Start,
   input  logic [2:0]       JpegComp,
   input  logic [1:0]       SubSamplingW,
   input  logic [1:0]       SubSamplingH,
   input  logic [POS_W-1:0] McuWidth,
   input  logic [POS_W-1:0] McuHeight,
   input  logic [15:0]      RestartInterval,
   input  logic             BlockDone,
   input  logic             RestartDone,
   output logic             DecodeEnable,
   output logic [2:0]       BlockColor,
   output logic [1:0]       BlockIndex,
   output logic [POS_W-1:0] McuX,
   output logic [POS_W-1:0] McuY,
   output logic             McuDone,
   output logic             RestartReq,
   output logic             DcReset,
   output logic             DecodeFinish
);

   sched_state_e     state_d, state_q;
   logic             comp3_d, comp3_q;
   logic [1:0]       last_idx_d, last_idx_q;
   logic [POS_W-1:0] width_d, width_q;
   logic [POS_W-1:0] height_d, height_q;
   logic [15:0]      interval_d, interval_q;
   logic [15:0]      rst_cnt_d, rst_cnt_q;
   logic [2:0]       color_d, color_q;
   logic [1:0]       index_d, index_q;
   logic             dec_en_d, dec_en_q;
   logic             mcu_done_d, mcu_done_q;
   logic             rst_req_d, rst_req_q;
   logic             dc_reset_d, dc_reset_q;
   logic             finish_d, finish_q;

   logic             pos_clr_s;
   logic             pos_adv_s;
   logic             pos_last_s;
   logic             mcu_end_s;
   logic [15:0]      cnt_inc_s;

   assign cnt_inc_s = rst_cnt_q + 16'd1;

   aq_djpeg_mcu_pos #(.POS_W(POS_W)) u_pos (
      .clk      (clk),
      .rst      (rst),
      .clr      (pos_clr_s),
      .adv      (pos_adv_s),
      .width    (width_q),
      .height   (height_q),
      .mcu_x    (McuX),
      .mcu_y    (McuY),
      .last_mcu (pos_last_s)
   );

   // Next state, block sequence, configuration latch and output pulses.
   always_comb begin
      state_d    = state_q;
      comp3_d    = comp3_q;
      last_idx_d = last_idx_q;
      width_d    = width_q;
      height_d   = height_q;
      interval_d = interval_q;
      rst_cnt_d  = rst_cnt_q;
      color_d    = color_q;
      index_d    = index_q;
      mcu_done_d = 1'b0;
      dc_reset_d = 1'b0;
      pos_clr_s  = 1'b0;
      pos_adv_s  = 1'b0;
      mcu_end_s  = 1'b0;

      if (ProcessInit) begin
         state_d    = ST_IDLE;
         comp3_d    = 1'b0;
         last_idx_d = 2'd0;
         width_d    = {POS_W{1'b0}};
         height_d   = {POS_W{1'b0}};
         interval_d = 16'd0;
         rst_cnt_d  = 16'd0;
         color_d    = COLOR_Y;
         index_d    = 2'd0;
         pos_clr_s  = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (Start) begin
                  comp3_d    = (JpegComp == COMP_COLOR);
                  last_idx_d = last_luma_index(SubSamplingW, SubSamplingH);
                  width_d    = McuWidth;
                  height_d   = McuHeight;
                  interval_d = RestartInterval;
                  rst_cnt_d  = 16'd0;
                  color_d    = COLOR_Y;
                  index_d    = 2'd0;
                  pos_clr_s  = 1'b1;
                  dc_reset_d = 1'b1;
                  state_d    = ST_RUN;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (BlockDone) begin
                  // Step through Y0..Y(N-1), then Cb, Cr for color scans.
                  if (color_q == COLOR_Y) begin
                     if (index_q == last_idx_q) begin
                        if (comp3_q) begin
                           color_d = COLOR_CB;
                           index_d = 2'd0;
                        end else begin
                           mcu_end_s = 1'b1;
                        end
                     end else begin
                        index_d = index_q + 2'd1;
                     end
                  end else if (color_q == COLOR_CB) begin
                     color_d = COLOR_CR;
                     index_d = 2'd0;
                  end else begin
                     mcu_end_s = 1'b1;
                  end

                  if (mcu_end_s) begin
                     mcu_done_d = 1'b1;
                     color_d    = COLOR_Y;
                     index_d    = 2'd0;
                     // End of scan takes priority over a restart on the same MCU.
                     if (pos_last_s) begin
                        state_d = ST_DONE;
                     end else begin
                        pos_adv_s = 1'b1;
                        if ((interval_q != 16'd0) && (cnt_inc_s == interval_q)) begin
                           rst_cnt_d = cnt_inc_s;
                           state_d   = ST_RESTART;
                        end else if (interval_q != 16'd0) begin
                           rst_cnt_d = cnt_inc_s;
                        end else begin
                           rst_cnt_d = 16'd0;
                        end
                     end
                  end else begin
                     mcu_done_d = 1'b0;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_RESTART: begin
               if (RestartDone) begin
                  dc_reset_d = 1'b1;
                  rst_cnt_d  = 16'd0;
                  state_d    = ST_RUN;
               end else begin
                  state_d = ST_RESTART;
               end
            end
            ST_DONE: begin
               state_d = ST_DONE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end

      // Level outputs follow the state being entered, so they stay registered.
      dec_en_d  = (state_d == ST_RUN);
      rst_req_d = (state_d == ST_RESTART);
      finish_d  = (state_d == ST_DONE);
   end

   // State, configuration and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         comp3_q    <= 1'b0;
         last_idx_q <= 2'd0;
         width_q    <= {POS_W{1'b0}};
         height_q   <= {POS_W{1'b0}};
         interval_q <= 16'd0;
         rst_cnt_q  <= 16'd0;
         color_q    <= COLOR_Y;
         index_q    <= 2'd0;
         dec_en_q   <= 1'b0;
         mcu_done_q <= 1'b0;
         rst_req_q  <= 1'b0;
         dc_reset_q <= 1'b0;
         finish_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         comp3_q    <= comp3_d;
         last_idx_q <= last_idx_d;
         width_q    <= width_d;
         height_q   <= height_d;
         interval_q <= interval_d;
         rst_cnt_q  <= rst_cnt_d;
         color_q    <= color_d;
         index_q    <= index_d;
         dec_en_q   <= dec_en_d;
         mcu_done_q <= mcu_done_d;
         rst_req_q  <= rst_req_d;
         dc_reset_q <= dc_reset_d;
         finish_q   <= finish_d;
      end
   end

   assign DecodeEnable = dec_en_q;
   assign BlockColor   = color_q;
   assign BlockIndex   = index_q;
   assign McuDone      = mcu_done_q;
   assign RestartReq   = rst_req_q;
   assign DcReset      = dc_reset_q;
   assign DecodeFinish = finish_q;

endmodule
